// File: rtl/led_sclk_div_if.sv
// Control and status bundle of the LED serial-clock divider.
// The master side programs ratio, polarity and bursts; the slave side is the divider itself.
interface led_sclk_div_if #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 8
);
   logic             en;
   logic             cpol;
   logic [DIV_W-1:0] div_half;
   logic             div_load;
   logic             burst_start;
   logic [CNT_W-1:0] burst_len;
   logic             clkoutd;
   logic             rise_stb;
   logic             fall_stb;
   logic             busy;
   logic             burst_done;
   logic             lock;

   modport master (
      output en, cpol, div_half, div_load, burst_start, burst_len,
      input  clkoutd, rise_stb, fall_stb, busy, burst_done, lock
   );

   modport slave (
      input  en, cpol, div_half, div_load, burst_start, burst_len,
      output clkoutd, rise_stb, fall_stb, busy, burst_done, lock
   );
endinterface

// File: rtl/led_sclk_div.sv
// Runtime-programmable serial clock divider with selectable idle level and counted bursts.
// Ratio updates wait for a period boundary so clkoutd never carries a runt phase.
module led_sclk_div #(
   parameter int DIV_W   = 8,
   parameter int CNT_W   = 8,
   parameter int RST_DIV = 25
) (
   input logic           clkin,
   input logic           reset,
   led_sclk_div_if.slave ctrl
);

   localparam logic [DIV_W-1:0] RST_H = (RST_DIV < 1) ? DIV_W'(1) : DIV_W'(RST_DIV);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FREE  = 2'd1,
      BURST = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] hActive_q, hActive_d;
   logic [DIV_W-1:0] pend_q, pend_d;
   logic             pendValid_q, pendValid_d;
   logic             lock_q, lock_d;
   logic             clk_q, clk_d;
   logic             polLatch_q, polLatch_d;
   logic [CNT_W-1:0] burstLen_q, burstLen_d;
   logic [CNT_W-1:0] periodCnt_q, periodCnt_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             apply;

   // State register; reset restores the power-on ratio and drops any pending one.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hActive_q   <= RST_H;
         pend_q      <= '0;
         pendValid_q <= 1'b0;
         lock_q      <= 1'b1;
         clk_q       <= 1'b0;
         polLatch_q  <= 1'b0;
         burstLen_q  <= '0;
         periodCnt_q <= '0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hActive_q   <= hActive_d;
         pend_q      <= pend_d;
         pendValid_q <= pendValid_d;
         lock_q      <= lock_d;
         clk_q       <= clk_d;
         polLatch_q  <= polLatch_d;
         burstLen_q  <= burstLen_d;
         periodCnt_q <= periodCnt_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state logic: half-period counting, boundary decisions and ratio hand-over.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hActive_d   = hActive_q;
      pend_d      = pend_q;
      pendValid_d = pendValid_q;
      clk_d       = clk_q;
      polLatch_d  = polLatch_q;
      burstLen_d  = burstLen_q;
      periodCnt_d = periodCnt_q;
      rise_d      = 1'b0;
      fall_d      = 1'b0;
      done_d      = 1'b0;
      apply       = 1'b0;

      case (state_q)
         IDLE: begin
            clk_d = ctrl.cpol;
            apply = pendValid_q;
            if (ctrl.burst_start && (ctrl.burst_len != '0)) begin
               state_d     = BURST;
               polLatch_d  = ctrl.cpol;
               cnt_d       = '0;
               burstLen_d  = ctrl.burst_len;
               periodCnt_d = '0;
            end else if (ctrl.en) begin
               state_d    = FREE;
               polLatch_d = ctrl.cpol;
               cnt_d      = '0;
            end
         end
         FREE, BURST: begin
            if (cnt_q == hActive_q - DIV_W'(1)) begin
               clk_d  = ~clk_q;
               cnt_d  = '0;
               rise_d = ~clk_q;
               fall_d = clk_q;
               // A toggle back to the latched idle level closes the period.
               if (clk_q != polLatch_q) begin
                  apply = pendValid_q;
                  if (state_q == FREE) begin
                     if (!ctrl.en) state_d = IDLE;
                  end else begin
                     periodCnt_d = periodCnt_q + CNT_W'(1);
                     if (periodCnt_q + CNT_W'(1) == burstLen_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (apply) begin
         hActive_d   = (pend_q == '0) ? DIV_W'(1) : pend_q;
         pendValid_d = 1'b0;
      end
      if (ctrl.div_load) begin
         pend_d      = ctrl.div_half;
         pendValid_d = 1'b1;
      end
      lock_d = ~ctrl.div_load & ~pendValid_q;
      busy_d = (state_d == BURST);
   end

   assign ctrl.clkoutd    = clk_q;
   assign ctrl.rise_stb   = rise_q;
   assign ctrl.fall_stb   = fall_q;
   assign ctrl.busy       = busy_q;
   assign ctrl.burst_done = done_q;
   assign ctrl.lock       = lock_q;

endmodule
